// File: rtl/vx_wctl_responder.sv
// vx_wctl_responder
//   Scheduler-side receiver of the warp-control channel. Consumes one message
//   per cycle (TMC / WSPAWN / BAR, any combination) and maintains the
//   active-warp mask, per-warp thread masks, barrier slots and stall mask.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   wctl_*              incoming warp-control message (always accepted)
//   active_warps        active-warp mask
//   thread_masks        per-warp thread masks, warp w at [w*NUM_THREADS +: NUM_THREADS]
//   stalled_warps       warps blocked at a barrier
//   spawn_valid/mask/pc one-cycle spawn notification for fetch
//   wctl_err            sticky protocol-error flag
module vx_wctl_responder #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NW_BITS      = $clog2(NUM_WARPS),
  parameter int NB_BITS      = $clog2(NUM_BARRIERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wctl_valid,
  input  logic [NW_BITS-1:0]               wctl_wid,
  input  logic                             wctl_tmc_valid,
  input  logic [NUM_THREADS-1:0]           wctl_tmc_mask,
  input  logic                             wctl_wspawn_valid,
  input  logic [NUM_WARPS-1:0]             wctl_wspawn_mask,
  input  logic [31:0]                      wctl_wspawn_pc,
  input  logic                             wctl_bar_valid,
  input  logic [NB_BITS-1:0]               wctl_bar_id,
  input  logic [NW_BITS-1:0]               wctl_bar_size_m1,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic [NUM_WARPS-1:0]             stalled_warps,
  output logic                             spawn_valid,
  output logic [NUM_WARPS-1:0]             spawn_mask,
  output logic [31:0]                      spawn_pc,
  output logic                             wctl_err
);

  localparam int TMW = NUM_WARPS * NUM_THREADS;

  logic [NUM_WARPS-1:0] r_active;
  logic [TMW-1:0]       r_tmask;
  logic [NUM_WARPS-1:0] r_stalled;
  logic                 r_spawn_valid;
  logic [NUM_WARPS-1:0] r_spawn_mask;
  logic [31:0]          r_spawn_pc;
  logic                 r_err;

  logic [NW_BITS-1:0]   r_bar_cnt  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] r_bar_wait [NUM_BARRIERS];
  logic [NW_BITS-1:0]   r_bar_size [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] w_wid_oh;
  logic                 w_accept;
  logic                 w_tmc_set;
  logic                 w_tmc_kill;
  logic [NUM_WARPS-1:0] w_spawn_new;
  logic                 w_bar_go;
  logic [NW_BITS-1:0]   w_cnt_cur;
  logic                 w_release;
  logic                 w_size_bad;
  logic [NUM_WARPS-1:0] w_active_nxt;
  logic [TMW-1:0]       w_tmask_nxt;
  logic [NUM_WARPS-1:0] w_stalled_nxt;
  logic                 w_err_nxt;

  assign w_wid_oh    = NUM_WARPS'(1) << wctl_wid;
  // Only running (active, not stalled) warps may issue warp-control messages.
  assign w_accept    = wctl_valid && r_active[wctl_wid] && !r_stalled[wctl_wid];
  assign w_tmc_set   = w_accept && wctl_tmc_valid && (wctl_tmc_mask != '0);
  assign w_tmc_kill  = w_accept && wctl_tmc_valid && (wctl_tmc_mask == '0);
  assign w_spawn_new = (w_accept && wctl_wspawn_valid) ?
                       (wctl_wspawn_mask & ~r_active & ~w_wid_oh) : '0;
  // A warp that switches itself off cannot also wait at a barrier.
  assign w_bar_go    = w_accept && wctl_bar_valid && !w_tmc_kill;
  assign w_cnt_cur   = r_bar_cnt[wctl_bar_id];
  assign w_release   = (w_cnt_cur == wctl_bar_size_m1);
  assign w_size_bad  = w_bar_go && (w_cnt_cur != '0) &&
                       (r_bar_size[wctl_bar_id] != wctl_bar_size_m1);

  always_comb begin
    w_active_nxt  = r_active | w_spawn_new;
    w_tmask_nxt   = r_tmask;
    w_stalled_nxt = r_stalled;
    if (w_tmc_kill)
      w_active_nxt[wctl_wid] = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (w_spawn_new[w])
        w_tmask_nxt[w*NUM_THREADS +: NUM_THREADS] = NUM_THREADS'(1);
    end
    if (w_tmc_set)
      w_tmask_nxt[int'(wctl_wid)*NUM_THREADS +: NUM_THREADS] = wctl_tmc_mask;
    if (w_bar_go) begin
      if (w_release)
        w_stalled_nxt = r_stalled & ~r_bar_wait[wctl_bar_id];
      else
        w_stalled_nxt = r_stalled | w_wid_oh;
    end
    w_err_nxt = r_err || (wctl_valid && !w_accept) ||
                (w_tmc_kill && wctl_bar_valid) || w_size_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active      <= NUM_WARPS'(1);
      r_tmask       <= TMW'(1);
      r_stalled     <= '0;
      r_spawn_valid <= 1'b0;
      r_spawn_mask  <= '0;
      r_spawn_pc    <= '0;
      r_err         <= 1'b0;
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
        r_bar_cnt[b]  <= '0;
        r_bar_wait[b] <= '0;
        r_bar_size[b] <= '0;
      end
    end else begin
      r_active      <= w_active_nxt;
      r_tmask       <= w_tmask_nxt;
      r_stalled     <= w_stalled_nxt;
      r_err         <= w_err_nxt;
      r_spawn_valid <= (w_spawn_new != '0);
      if (w_spawn_new != '0) begin
        r_spawn_mask <= w_spawn_new;
        r_spawn_pc   <= wctl_wspawn_pc;
      end
      if (w_bar_go) begin
        if (w_release) begin
          r_bar_cnt[wctl_bar_id]  <= '0;
          r_bar_wait[wctl_bar_id] <= '0;
        end else begin
          r_bar_cnt[wctl_bar_id]  <= w_cnt_cur + 1'b1;
          r_bar_wait[wctl_bar_id] <= r_bar_wait[wctl_bar_id] | w_wid_oh;
          // The first arrival fixes the reference size for consistency checks.
          if (w_cnt_cur == '0)
            r_bar_size[wctl_bar_id] <= wctl_bar_size_m1;
        end
      end
    end
  end

  assign active_warps  = r_active;
  assign thread_masks  = r_tmask;
  assign stalled_warps = r_stalled;
  assign spawn_valid   = r_spawn_valid;
  assign spawn_mask    = r_spawn_mask;
  assign spawn_pc      = r_spawn_pc;
  assign wctl_err      = r_err;

endmodule

// File: tb/tb_vx_wctl_responder.sv
module tb_vx_wctl_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wctl_valid = 1'b0;
  logic [1:0]  wctl_wid = '0;
  logic        wctl_tmc_valid = 1'b0;
  logic [3:0]  wctl_tmc_mask = '0;
  logic        wctl_wspawn_valid = 1'b0;
  logic [3:0]  wctl_wspawn_mask = '0;
  logic [31:0] wctl_wspawn_pc = '0;
  logic        wctl_bar_valid = 1'b0;
  logic [1:0]  wctl_bar_id = '0;
  logic [1:0]  wctl_bar_size_m1 = '0;
  logic [3:0]  active_warps;
  logic [15:0] thread_masks;
  logic [3:0]  stalled_warps;
  logic        spawn_valid;
  logic [3:0]  spawn_mask;
  logic [31:0] spawn_pc;
  logic        wctl_err;

  int checks = 0;
  int failures = 0;

  vx_wctl_responder #(.NUM_WARPS(4), .NUM_THREADS(4), .NUM_BARRIERS(4)) dut (
    .clk(clk), .reset(reset), .wctl_valid(wctl_valid), .wctl_wid(wctl_wid),
    .wctl_tmc_valid(wctl_tmc_valid), .wctl_tmc_mask(wctl_tmc_mask),
    .wctl_wspawn_valid(wctl_wspawn_valid), .wctl_wspawn_mask(wctl_wspawn_mask),
    .wctl_wspawn_pc(wctl_wspawn_pc), .wctl_bar_valid(wctl_bar_valid),
    .wctl_bar_id(wctl_bar_id), .wctl_bar_size_m1(wctl_bar_size_m1),
    .active_warps(active_warps), .thread_masks(thread_masks),
    .stalled_warps(stalled_warps), .spawn_valid(spawn_valid),
    .spawn_mask(spawn_mask), .spawn_pc(spawn_pc), .wctl_err(wctl_err));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (warp-level bookkeeping) ----------------
  bit          m_act [4];
  int          m_tm  [4];
  bit          m_stl [4];
  int          m_q   [4][$];   // warps waiting at each barrier slot
  int          m_fsz [4];      // size_m1 given by the first waiter
  bit          m_err;
  bit          m_spv;
  logic [3:0]  m_spm;
  logic [31:0] m_spc;

  task automatic model_reset();
    for (int w = 0; w < 4; w++) begin
      m_act[w] = (w == 0);
      m_tm[w]  = (w == 0) ? 1 : 0;
      m_stl[w] = 0;
    end
    for (int b = 0; b < 4; b++) begin
      m_q[b].delete();
      m_fsz[b] = 0;
    end
    m_err = 0; m_spv = 0; m_spm = '0; m_spc = '0;
  endtask

  task automatic model_step(input bit v, input int wid, input bit tmc, input int tm,
                            input bit sp, input logic [3:0] spm, input logic [31:0] pc,
                            input bit bar, input int bid, input int bsz);
    logic [3:0] nw;
    bit was_act [4];
    m_spv = 0;
    if (!v) return;
    if (!m_act[wid] || m_stl[wid]) begin
      m_err = 1;
      return;
    end
    for (int w = 0; w < 4; w++) was_act[w] = m_act[w];
    nw = '0;
    if (sp) begin
      for (int w = 0; w < 4; w++)
        if (spm[w] && !was_act[w] && w != wid) begin
          nw[w] = 1'b1; m_act[w] = 1; m_tm[w] = 1;
        end
      if (nw != 0) begin
        m_spv = 1; m_spm = nw; m_spc = pc;
      end
    end
    if (tmc) begin
      if (tm == 0) m_act[wid] = 0;
      else m_tm[wid] = tm;
    end
    if (bar) begin
      if (tmc && tm == 0) m_err = 1;
      else begin
        if (m_q[bid].size() > 0 && bsz != m_fsz[bid]) m_err = 1;
        if (m_q[bid].size() == bsz) begin
          foreach (m_q[bid][i]) m_stl[m_q[bid][i]] = 0;
          m_q[bid].delete();
        end else begin
          if (m_q[bid].size() == 0) m_fsz[bid] = bsz;
          m_q[bid].push_back(wid);
          m_stl[wid] = 1;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic send(input logic [1:0] wid, input bit tmc, input logic [3:0] tm,
                      input bit sp, input logic [3:0] spm, input logic [31:0] pc,
                      input bit bar, input logic [1:0] bid, input logic [1:0] bsz);
    wctl_valid = 1'b1; wctl_wid = wid;
    wctl_tmc_valid = tmc; wctl_tmc_mask = tm;
    wctl_wspawn_valid = sp; wctl_wspawn_mask = spm; wctl_wspawn_pc = pc;
    wctl_bar_valid = bar; wctl_bar_id = bid; wctl_bar_size_m1 = bsz;
    @(posedge clk); #1;
    wctl_valid = 1'b0; wctl_tmc_valid = 1'b0; wctl_wspawn_valid = 1'b0; wctl_bar_valid = 1'b0;
  endtask

  task automatic bar_msg(input logic [1:0] wid, input logic [1:0] bid, input logic [1:0] bsz);
    send(wid, 0, 4'h0, 0, 4'h0, 32'h0, 1, bid, bsz);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    idle();
    checks++; if (active_warps !== 4'b0001) begin failures++; $display("FAIL reset_active got=%b exp=0001", active_warps); end
    checks++; if (thread_masks !== 16'h0001) begin failures++; $display("FAIL reset_tmask got=%h exp=0001", thread_masks); end
    checks++; if (stalled_warps !== 4'b0000) begin failures++; $display("FAIL reset_stalled got=%b exp=0000", stalled_warps); end
    checks++; if (spawn_valid !== 1'b0 || spawn_mask !== 4'h0 || spawn_pc !== 32'h0) begin failures++; $display("FAIL reset_spawn got=%b/%b/%h exp=0/0000/0", spawn_valid, spawn_mask, spawn_pc); end
    checks++; if (wctl_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", wctl_err); end
  endtask

  task automatic test_spawn();
    send(2'd0, 0, 4'h0, 1, 4'b1111, 32'h8000_0100, 0, 2'd0, 2'd0);
    checks++; if (active_warps !== 4'b1111) begin failures++; $display("FAIL spawn_active got=%b exp=1111", active_warps); end
    checks++; if (thread_masks !== 16'h1111) begin failures++; $display("FAIL spawn_tmask got=%h exp=1111", thread_masks); end
    checks++; if (spawn_valid !== 1'b1 || spawn_mask !== 4'b1110 || spawn_pc !== 32'h8000_0100) begin failures++; $display("FAIL spawn_pulse got=%b/%b/%h exp=1/1110/80000100", spawn_valid, spawn_mask, spawn_pc); end
    idle();
    checks++; if (spawn_valid !== 1'b0) begin failures++; $display("FAIL spawn_one_cycle got=%b exp=0", spawn_valid); end
    send(2'd0, 0, 4'h0, 1, 4'b1111, 32'h8000_0100, 0, 2'd0, 2'd0);
    checks++; if (spawn_valid !== 1'b0 || active_warps !== 4'b1111) begin failures++; $display("FAIL spawn_repeat got=%b/%b exp=0/1111", spawn_valid, active_warps); end
  endtask

  task automatic test_tmc();
    send(2'd1, 1, 4'b1010, 0, 4'h0, 32'h0, 0, 2'd0, 2'd0);
    checks++; if (thread_masks !== 16'h11A1 || active_warps !== 4'b1111) begin failures++; $display("FAIL tmc_set got=%h/%b exp=11a1/1111", thread_masks, active_warps); end
    send(2'd1, 1, 4'b0000, 0, 4'h0, 32'h0, 0, 2'd0, 2'd0);
    checks++; if (active_warps !== 4'b1101 || thread_masks !== 16'h11A1) begin failures++; $display("FAIL tmc_zero got=%b/%h exp=1101/11a1", active_warps, thread_masks); end
    checks++; if (wctl_err !== 1'b0) begin failures++; $display("FAIL tmc_err got=%b exp=0", wctl_err); end
  endtask

  task automatic test_barrier();
    for (int rep = 0; rep < 2; rep++) begin
      bar_msg(2'd0, 2'd2, 2'd2);
      checks++; if (stalled_warps !== 4'b0001) begin failures++; $display("FAIL bar_arrive1 rep=%0d got=%b exp=0001", rep, stalled_warps); end
      bar_msg(2'd3, 2'd2, 2'd2);
      checks++; if (stalled_warps !== 4'b1001) begin failures++; $display("FAIL bar_arrive2 rep=%0d got=%b exp=1001", rep, stalled_warps); end
      bar_msg(2'd2, 2'd2, 2'd2);
      checks++; if (stalled_warps !== 4'b0000) begin failures++; $display("FAIL bar_release rep=%0d got=%b exp=0000", rep, stalled_warps); end
    end
    checks++; if (wctl_err !== 1'b0) begin failures++; $display("FAIL bar_err got=%b exp=0", wctl_err); end
  endtask

  task automatic test_stalled_err();
    bar_msg(2'd0, 2'd1, 2'd0);
    checks++; if (stalled_warps !== 4'b0000 || wctl_err !== 1'b0) begin failures++; $display("FAIL bar_size0 got=%b/%b exp=0000/0", stalled_warps, wctl_err); end
    bar_msg(2'd3, 2'd0, 2'd1);
    checks++; if (stalled_warps !== 4'b1000) begin failures++; $display("FAIL stall_w3 got=%b exp=1000", stalled_warps); end
    send(2'd3, 1, 4'b0011, 0, 4'h0, 32'h0, 0, 2'd0, 2'd0);
    checks++; if (wctl_err !== 1'b1 || thread_masks !== 16'h11A1 || active_warps !== 4'b1101) begin failures++; $display("FAIL stalled_msg got=%b/%h/%b exp=1/11a1/1101", wctl_err, thread_masks, active_warps); end
    bar_msg(2'd0, 2'd0, 2'd1);
    checks++; if (stalled_warps !== 4'b0000 || wctl_err !== 1'b1) begin failures++; $display("FAIL stall_release got=%b/%b exp=0000/1", stalled_warps, wctl_err); end
  endtask

  task automatic test_reset_mid_barrier();
    send(2'd0, 0, 4'h0, 1, 4'b1111, 32'h0000_2000, 0, 2'd0, 2'd0);
    checks++; if (spawn_mask !== 4'b0010 || active_warps !== 4'b1111) begin failures++; $display("FAIL respawn got=%b/%b exp=0010/1111", spawn_mask, active_warps); end
    bar_msg(2'd0, 2'd3, 2'd3);
    bar_msg(2'd1, 2'd3, 2'd3);
    checks++; if (stalled_warps !== 4'b0011) begin failures++; $display("FAIL mid_stall got=%b exp=0011", stalled_warps); end
    #2 reset = 1'b1;
    #1;
    checks++; if (active_warps !== 4'b0001 || thread_masks !== 16'h0001 || stalled_warps !== 4'b0000) begin failures++; $display("FAIL async_reset_state got=%b/%h/%b exp=0001/0001/0000", active_warps, thread_masks, stalled_warps); end
    checks++; if (wctl_err !== 1'b0 || spawn_valid !== 1'b0 || spawn_mask !== 4'h0 || spawn_pc !== 32'h0) begin failures++; $display("FAIL async_reset_flags got=%b/%b/%b/%h exp=0/0/0000/0", wctl_err, spawn_valid, spawn_mask, spawn_pc); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    send(2'd0, 0, 4'h0, 1, 4'b1111, 32'h0000_3000, 0, 2'd0, 2'd0);
    bar_msg(2'd0, 2'd3, 2'd1);
    checks++; if (stalled_warps !== 4'b0001) begin failures++; $display("FAIL post_reset_arrive got=%b exp=0001", stalled_warps); end
    bar_msg(2'd1, 2'd3, 2'd1);
    checks++; if (stalled_warps !== 4'b0000 || wctl_err !== 1'b0) begin failures++; $display("FAIL post_reset_release got=%b/%b exp=0000/0", stalled_warps, wctl_err); end
  endtask

  task automatic test_inconsistent_size();
    bar_msg(2'd0, 2'd0, 2'd2);
    checks++; if (stalled_warps !== 4'b0001 || wctl_err !== 1'b0) begin failures++; $display("FAIL incons_first got=%b/%b exp=0001/0", stalled_warps, wctl_err); end
    bar_msg(2'd2, 2'd0, 2'd1);
    checks++; if (stalled_warps !== 4'b0000 || wctl_err !== 1'b1) begin failures++; $display("FAIL incons_release got=%b/%b exp=0000/1", stalled_warps, wctl_err); end
  endtask

  task automatic test_random();
    int slot_sz [4];
    logic [3:0]  e_act, e_stl;
    logic [15:0] e_tm;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        do_reset();
        model_reset();
        for (int b = 0; b < 4; b++) slot_sz[b] = $urandom_range(0, 3);
      end
      begin
        bit v, tmc, sp, bar;
        int wid, tm, bid;
        logic [3:0] spm;
        logic [31:0] pc;
        v   = ($urandom_range(0, 9) < 8);
        wid = $urandom_range(0, 3);
        tmc = ($urandom_range(0, 3) == 0);
        tm  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
        sp  = ($urandom_range(0, 3) == 0);
        spm = 4'($urandom);
        pc  = $urandom;
        bar = ($urandom_range(0, 2) == 0);
        bid = $urandom_range(0, 3);
        if (v) send(2'(wid), tmc, 4'(tm), sp, spm, pc, bar, 2'(bid), 2'(slot_sz[bid]));
        else idle();
        model_step(v, wid, tmc, tm, sp, spm, pc, bar, bid, slot_sz[bid]);
        for (int w = 0; w < 4; w++) begin
          e_act[w] = m_act[w];
          e_stl[w] = m_stl[w];
          e_tm[w*4 +: 4] = 4'(m_tm[w]);
        end
        checks++; if (active_warps !== e_act) begin failures++; $display("FAIL rnd_active n=%0d got=%b exp=%b", n, active_warps, e_act); end
        checks++; if (thread_masks !== e_tm) begin failures++; $display("FAIL rnd_tmask n=%0d got=%h exp=%h", n, thread_masks, e_tm); end
        checks++; if (stalled_warps !== e_stl) begin failures++; $display("FAIL rnd_stalled n=%0d got=%b exp=%b", n, stalled_warps, e_stl); end
        checks++; if (spawn_valid !== m_spv) begin failures++; $display("FAIL rnd_spawn_valid n=%0d got=%b exp=%b", n, spawn_valid, m_spv); end
        if (m_spv) begin
          checks++; if (spawn_mask !== m_spm || spawn_pc !== m_spc) begin failures++; $display("FAIL rnd_spawn n=%0d got=%b/%h exp=%b/%h", n, spawn_mask, spawn_pc, m_spm, m_spc); end
        end
        checks++; if (wctl_err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, wctl_err, m_err); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_tmc();
    test_barrier();
    test_stalled_err();
    test_reset_mid_barrier();
    test_inconsistent_size();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_wctl_responder.md
Name: vx_wctl_responder

Overview:
- Receiving end of the warp-control channel driven by the SFU warp-control path.
- Sits in the scheduler and consumes one warp-control message per cycle: thread-mask change (TMC), warp spawn (WSPAWN) and barrier arrival (BAR).
- Maintains the active-warp mask, per-warp thread masks, barrier bookkeeping and the warp stall mask.
- Produces a one-cycle spawn notification carrying the start PC for fetch.

Parameters:
NUM_WARPS, 4, number of hardware warps (power of two, >=2)
NUM_THREADS, 4, threads per warp
NUM_BARRIERS, 4, number of barrier slots (power of two)
NW_BITS, clog2(NUM_WARPS), warp-id width
NB_BITS, clog2(NUM_BARRIERS), barrier-id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wctl_valid  in  1  message valid; no backpressure, always accepted
wctl_wid  in  NW_BITS  issuing warp
wctl_tmc_valid  in  1  message carries TMC
wctl_tmc_mask  in  NUM_THREADS  new thread mask
wctl_wspawn_valid  in  1  message carries WSPAWN
wctl_wspawn_mask  in  NUM_WARPS  warps to activate
wctl_wspawn_pc  in  32  start PC of spawned warps
wctl_bar_valid  in  1  message carries BAR
wctl_bar_id  in  NB_BITS  barrier slot
wctl_bar_size_m1  in  NW_BITS  participating warps minus one
active_warps  out  NUM_WARPS  active-warp mask
thread_masks  out  NUM_WARPS*NUM_THREADS  per-warp thread masks; warp w at bits [w*NUM_THREADS +: NUM_THREADS]
stalled_warps  out  NUM_WARPS  warps blocked at a barrier
spawn_valid  out  1  one-cycle pulse on WSPAWN
spawn_mask  out  NUM_WARPS  warps newly activated
spawn_pc  out  32  start PC
wctl_err  out  1  sticky protocol-error flag

Behaviour:
- One clock, clk. reset is asynchronous and active-high, named reset.
- Reset values:
  - active_warps = 1 (warp 0 only).
  - thread_masks: warp 0 = 1 (thread 0 only); all other warps 0.
  - stalled_warps = 0.
  - spawn_valid = 0; spawn_mask = 0; spawn_pc = 0.
  - wctl_err = 0.
  - All barrier counters and waiting masks = 0.
- Reset asserted mid-operation discards every pending barrier and returns all state to the reset values.
- All outputs are registered. A message accepted in cycle N is visible in cycle N+1. No internal queuing.
- A message is ignored when wctl_valid=0. The sub-flags tmc/wspawn/bar are sampled only when wctl_valid=1. Several sub-flags may be set together; all are applied in the same cycle.
- Message from a warp that is stalled or inactive: the message is ignored and wctl_err sets (sticky until reset).
- TMC:
  - mask != 0: thread_masks[wid] <= mask; warp wid stays active.
  - mask == 0: active_warps[wid] <= 0; thread_masks[wid] is left unchanged.
- WSPAWN:
  - new = wspawn_mask & ~active_warps & ~(1<<wid).
  - active_warps |= new.
  - thread_masks of each warp in new <= 1.
  - spawn_valid pulses for one cycle with spawn_mask = new and spawn_pc = wctl_wspawn_pc.
  - If new == 0, there is no pulse.
  - Already-active warps are untouched.
- BAR, per slot b: count[b] (NW_BITS wide) and wait[b] (NUM_WARPS wide).
  - count[b] != size_m1 (arrival): count[b]++, wait[b] |= 1<<wid, stalled_warps[wid] <= 1.
  - count[b] == size_m1 (release): stalled_warps &= ~wait[b]; count[b] <= 0; wait[b] <= 0. The arriving warp is never stalled.
  - size_m1 == 0: immediate release with no stall.
- TMC+BAR in the same message:
  - Mask update and barrier arrival both apply.
  - If TMC deactivates the warp (mask 0), the BAR part is dropped and wctl_err sets.
- Counter wrap: count cannot exceed size_m1 < NUM_WARPS, so it never wraps.
- An inconsistent size_m1 across arrivals on a busy slot (differs from the first arrival's value) sets wctl_err. The latest value is used for the release compare.
- Separate barrier slots are fully independent.

Test Plan:
- Reset, then idle -> active_warps=0001, thread_masks warp0=0001, stalled_warps=0000, spawn_valid=0, wctl_err=0.
- Warp0 WSPAWN mask=1111, pc=0x80000100 -> next cycle: active_warps=1111, warps1-3 thread mask=0001, one-cycle spawn_valid with spawn_mask=1110, spawn_pc=0x80000100. Repeating the same message -> no pulse.
- Warp1 TMC mask=1010 -> thread_masks warp1=1010. Then warp1 TMC mask=0000 -> active_warps bit1 clears and warp1 mask stays 1010.
- Barrier 2, size_m1=2: warp0 and warp3 arrive -> stalled=1001 after the second arrival; warp2 arrives -> stalled=0000 the next cycle and count[2]=0. Reuse of barrier 2 behaves identically.
- Warp0 BAR id=1 size_m1=0 -> never stalled. Message from stalled warp3 (barrier 0 waiting) -> ignored, wctl_err=1.
- Assert reset mid-barrier (stalled=0011) -> immediately returns to reset values; a later full barrier sequence works.
